// File: rtl/udp_rxq_commit.sv
// Receive quarantine queue for the Ethernet/UDP receive path.
// Payload words are written into a single RAM as they arrive. A packet only
// becomes readable once its good verdict (rxlast) has been seen and it meets
// the minimum length. Rejected packets are removed by rolling wr_ptr back to
// the packet's first word, so bad data never reaches the consumer.
module udp_rxq_commit #(
  parameter int W            = 8,
  parameter int AW           = 11,
  parameter int VALID_WINDOW = 26,
  parameter int MIN_LEN      = 1,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  rxd,
  input  logic          rxdv,
  input  logic          rxlast,
  output logic [W-1:0]  qrxd,
  output logic          qrxdv,
  output logic          qrxlast,
  input  logic          qrxready,
  output logic [CW-1:0] good_cnt,
  output logic [CW-1:0] drop_cnt,
  output logic [CW-1:0] ovf_cnt
);

  localparam int            TW        = $clog2(VALID_WINDOW + 1);
  localparam logic [AW:0]   DEPTH_P   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   MIN_LEN_P = MIN_LEN[AW:0];
  localparam logic [AW:0]   LEN_MAX   = '1;
  localparam logic [TW-1:0] WIN_LAST  = TW'(VALID_WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DISCARD,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  // Input delay stage: a word is written one cycle late so that, when rxdv
  // falls, the word being written is known to be the last one.
  logic [W-1:0]  rxd_q;
  logic          rxdv_q;

  logic [AW:0]   wr_ptr, commit_ptr, rd_ptr, pkt_start;
  logic [AW:0]   len;
  logic [AW:0]   used;
  logic          full;
  logic          good;
  logic [TW-1:0] timer;

  logic          rise;
  logic          wr_en;
  logic          wr_eop;
  logic          start_pkt;
  logic          resolve;
  logic          commit_ok;
  logic          ovf_evt;

  logic [W:0]    mem [2**AW];
  logic [W:0]    ram_q;
  logic          mid_valid;
  logic          pop;
  logic          out_load;
  logic          rd_en;

  assign rise      = rxdv & ~rxdv_q;
  assign used      = wr_ptr - rd_ptr;
  assign full      = (used == DEPTH_P);
  assign wr_eop    = ~rxdv;
  assign commit_ok = (good | rxlast) && (len >= MIN_LEN_P);

  // Ingest state register; a packet still streaming when reset drops is skipped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and process ordering cannot change the result.
    if (rst) state <= rxdv ? S_DISCARD : S_IDLE;
    else     state <= state_nxt;
  end

  // Ingest next-state and control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt = state;
    wr_en     = 1'b0;
    start_pkt = 1'b0;
    resolve   = 1'b0;
    ovf_evt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_nxt = S_RECV;
          start_pkt = 1'b1;
        end
      end
      S_RECV: begin
        // The delayed stage always holds a word while in RECV.
        if (full) begin
          ovf_evt   = 1'b1;
          state_nxt = rxdv ? S_DISCARD : S_IDLE;
        end else begin
          wr_en = 1'b1;
          if (!rxdv) state_nxt = S_WAIT;
        end
      end
      S_DISCARD: begin
        if (!rxdv) state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (rise || good || rxlast || (timer == WIN_LAST)) begin
          resolve = 1'b1;
          if (rise) begin
            state_nxt = S_RECV;
            start_pkt = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ingest datapath: pointers, packet bookkeeping, verdict window, statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_q      <= '0;
      rxdv_q     <= 1'b0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pkt_start  <= '0;
      len        <= '0;
      good       <= 1'b0;
      timer      <= '0;
      good_cnt   <= '0;
      drop_cnt   <= '0;
      ovf_cnt    <= '0;
    end else begin
      rxd_q  <= rxd;
      rxdv_q <= rxdv;

      if (ovf_evt)                   wr_ptr <= pkt_start;
      else if (wr_en)                wr_ptr <= wr_ptr + 1'b1;
      else if (resolve && !commit_ok) wr_ptr <= pkt_start;

      if (resolve && commit_ok) commit_ptr <= wr_ptr;

      // A forced resolve starts the new packet at the post-rollback pointer.
      if (start_pkt) pkt_start <= (resolve && !commit_ok) ? pkt_start : wr_ptr;

      if (start_pkt)                    len <= '0;
      else if (wr_en && len != LEN_MAX) len <= len + 1'b1;

      // The rise that starts a packet clears the flag even if rxlast is high,
      // because that rxlast belongs to the previous packet.
      if (start_pkt)   good <= 1'b0;
      else if (rxlast) good <= 1'b1;

      timer <= (state == S_WAIT && state_nxt == S_WAIT) ? timer + 1'b1 : '0;

      if (resolve && commit_ok && good_cnt != '1)  good_cnt <= good_cnt + 1'b1;
      if (resolve && !commit_ok && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (ovf_evt && ovf_cnt != '1)                ovf_cnt  <= ovf_cnt + 1'b1;
    end
  end

  // Packet RAM: each word is {eop, data}.
  always_ff @(posedge clk) begin
    // NOTE: the RAM is deliberately not reset; pointers alone decide which
    // entries are meaningful, and a reset would block RAM inference.
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {wr_eop, rxd_q};
  end

  // Synchronous read port; ram_q holds its value while no read is issued,
  // so it doubles as the middle stage of the show-ahead pipeline.
  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem[rd_ptr[AW-1:0]];
  end

  assign pop      = qrxdv & qrxready;
  assign out_load = mid_valid & (~qrxdv | pop);
  assign rd_en    = (rd_ptr != commit_ptr) & (~mid_valid | out_load);

  // Output pipeline: read committed words and present them with backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      mid_valid <= 1'b0;
      qrxdv     <= 1'b0;
      qrxlast   <= 1'b0;
      qrxd      <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      mid_valid <= rd_en | (mid_valid & ~out_load);
      if (out_load) {qrxlast, qrxd} <= ram_q;
      qrxdv <= out_load | (qrxdv & ~pop);
    end
  end

endmodule

// File: tb/tb_udp_rxq_commit.sv
// Self-checking bench for udp_rxq_commit. Two instances: a default-sized
// queue and a 16-word queue with a 4-word minimum length. Expected words are
// queued when stimulus is issued; monitors pop and compare on every accepted
// output word.
module tb_udp_rxq_commit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-sized instance
  logic [7:0]  rxd_a = '0;
  logic        rxdv_a = 1'b0, rxlast_a = 1'b0, qrxready_a = 1'b0;
  logic [7:0]  qrxd_a;
  logic        qrxdv_a, qrxlast_a;
  logic [15:0] good_a, drop_a, ovf_a;

  // Small instance (16 words, MIN_LEN 4)
  logic [7:0]  rxd_b = '0;
  logic        rxdv_b = 1'b0, rxlast_b = 1'b0, qrxready_b = 1'b0;
  logic [7:0]  qrxd_b;
  logic        qrxdv_b, qrxlast_b;
  logic [15:0] good_b, drop_b, ovf_b;

  udp_rxq_commit #(.W(8), .AW(11), .VALID_WINDOW(26), .MIN_LEN(1), .CW(16)) u_big (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rxdv(rxdv_a), .rxlast(rxlast_a),
    .qrxd(qrxd_a), .qrxdv(qrxdv_a), .qrxlast(qrxlast_a), .qrxready(qrxready_a),
    .good_cnt(good_a), .drop_cnt(drop_a), .ovf_cnt(ovf_a)
  );

  udp_rxq_commit #(.W(8), .AW(4), .VALID_WINDOW(26), .MIN_LEN(4), .CW(16)) u_small (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rxdv(rxdv_b), .rxlast(rxlast_b),
    .qrxd(qrxd_b), .qrxdv(qrxdv_b), .qrxlast(qrxlast_b), .qrxready(qrxready_b),
    .good_cnt(good_b), .drop_cnt(drop_b), .ovf_cnt(ovf_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the default instance: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (!rst && qrxdv_a && qrxready_a) begin
      if (exp_a.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_word: got 0x%0h, expected no word (t=%0t)",
                 {qrxlast_a, qrxd_a}, $time);
      end else begin
        logic [8:0] e;
        e = exp_a.pop_front();
        check("a_word", {23'd0, qrxlast_a, qrxd_a}, {23'd0, e});
      end
    end
  end

  // Monitor for the small instance.
  always @(negedge clk) begin
    if (!rst && qrxdv_b && qrxready_b) begin
      if (exp_b.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_word: got 0x%0h, expected no word (t=%0t)",
                 {qrxlast_b, qrxd_b}, $time);
      end else begin
        logic [8:0] e;
        e = exp_b.pop_front();
        check("b_word", {23'd0, qrxlast_b, qrxd_b}, {23'd0, e});
      end
    end
  end

  // Hard stop in case something never terminates.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic put(input int sel, input logic dv, input logic [7:0] d, input logic last);
    if (sel == 0) begin
      rxdv_a = dv; rxd_a = d; rxlast_a = last;
    end else begin
      rxdv_b = dv; rxd_b = d; rxlast_b = last;
    end
  endtask

  // Drive n words base..base+n-1; rxlast pulses on word index last_at (-1: none).
  task automatic send(input int sel, input int n, input int base, input int last_at);
    for (int i = 0; i < n; i++) begin
      put(sel, 1'b1, 8'(base + i), i == last_at);
      tick();
    end
    put(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic expect_pkt(input int sel, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      logic [8:0] w;
      w = {(i == n - 1), 8'(base + i)};
      if (sel == 0) exp_a.push_back(w);
      else          exp_b.push_back(w);
    end
  endtask

  task automatic drain(input int sel, input int budget);
    int k;
    int left;
    k = 0;
    left = (sel == 0) ? exp_a.size() : exp_b.size();
    while (left != 0 && k < budget) begin
      tick();
      k++;
      left = (sel == 0) ? exp_a.size() : exp_b.size();
    end
    check(sel == 0 ? "a_drain_left" : "b_drain_left", left, 0);
  endtask

  initial begin
    // Reset
    idle(3);
    @(negedge clk);
    check("rst_qrxdv_a",   {31'd0, qrxdv_a},   0);
    check("rst_qrxlast_a", {31'd0, qrxlast_a}, 0);
    check("rst_good_a",    {16'd0, good_a},    0);
    check("rst_drop_a",    {16'd0, drop_a},    0);
    check("rst_ovf_a",     {16'd0, ovf_a},     0);
    check("rst_qrxdv_b",   {31'd0, qrxdv_b},   0);
    rst = 1'b0;
    tick();

    // 1: 64-word packet, rxlast 10 cycles after the end, check commit latency
    qrxready_a = 1'b1;
    expect_pkt(0, 64, 8'h00);
    send(0, 64, 8'h00, -1);
    idle(10);
    put(0, 1'b0, 8'h00, 1'b1);
    tick();                       // commit takes effect on this edge
    put(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("lat_cycle1_qrxdv", {31'd0, qrxdv_a}, 0);
    tick();
    @(negedge clk);
    check("lat_cycle2_qrxdv", {31'd0, qrxdv_a}, 0);
    tick();
    @(negedge clk);
    check("lat_cycle3_qrxdv", {31'd0, qrxdv_a}, 1);
    drain(0, 200);
    check("t1_good", {16'd0, good_a}, 1);
    check("t1_drop", {16'd0, drop_a}, 0);

    // 2: 20 words without rxlast (late rxlast is ignored), then 8 good words
    send(0, 20, 8'h80, -1);
    idle(35);
    put(0, 1'b0, 8'h00, 1'b1);
    tick();
    put(0, 1'b0, 8'h00, 1'b0);
    idle(4);
    check("t2_drop",  {16'd0, drop_a},   1);
    check("t2_good",  {16'd0, good_a},   1);
    check("t2_qrxdv", {31'd0, qrxdv_a},  0);
    expect_pkt(0, 8, 8'h40);
    send(0, 8, 8'h40, 7);
    idle(3);
    drain(0, 50);
    check("t2b_good", {16'd0, good_a}, 2);

    // 4: A then B after one idle cycle; rxlast during B belongs to B
    expect_pkt(0, 6, 8'h20);
    send(0, 5, 8'h10, -1);
    tick();
    send(0, 6, 8'h20, 2);
    idle(3);
    drain(0, 50);
    check("t4_good", {16'd0, good_a}, 3);
    check("t4_drop", {16'd0, drop_a}, 2);

    // 4b: rxlast coincident with B's rise belongs to A
    expect_pkt(0, 3, 8'h30);
    expect_pkt(0, 4, 8'h50);
    send(0, 3, 8'h30, -1);
    tick();
    send(0, 4, 8'h50, 0);
    idle(2);
    put(0, 1'b0, 8'h00, 1'b1);
    tick();
    put(0, 1'b0, 8'h00, 1'b0);
    idle(3);
    drain(0, 50);
    check("t4b_good", {16'd0, good_a}, 5);
    check("t4b_drop", {16'd0, drop_a}, 2);

    // 3: small queue, output stalled, 20-word packet overflows
    qrxready_b = 1'b0;
    send(1, 20, 8'h60, 19);
    idle(30);
    check("t3_ovf",   {16'd0, ovf_b},   1);
    check("t3_drop",  {16'd0, drop_b},  0);
    check("t3_good",  {16'd0, good_b},  0);
    check("t3_qrxdv", {31'd0, qrxdv_b}, 0);
    qrxready_b = 1'b1;
    expect_pkt(1, 10, 8'h70);
    send(1, 10, 8'h70, 9);
    idle(3);
    drain(1, 50);
    check("t3b_good", {16'd0, good_b}, 1);

    // 5: runt (3 < MIN_LEN) dropped, 4-word packet accepted
    send(1, 3, 8'h90, 2);
    idle(5);
    check("t5_drop",  {16'd0, drop_b},  1);
    check("t5_qrxdv", {31'd0, qrxdv_b}, 0);
    expect_pkt(1, 4, 8'hA0);
    send(1, 4, 8'hA0, 3);
    idle(3);
    drain(1, 50);
    check("t5_good", {16'd0, good_b}, 2);
    check("t5_ovf",  {16'd0, ovf_b},  1);

    // 6: reset mid-packet with 5 committed words stalled at the output
    qrxready_a = 1'b0;
    send(0, 5, 8'hC0, 4);
    idle(8);
    @(negedge clk);
    check("t6_stall_qrxdv",   {31'd0, qrxdv_a},   1);
    check("t6_stall_qrxd",    {24'd0, qrxd_a},    32'hC0);
    check("t6_stall_qrxlast", {31'd0, qrxlast_a}, 0);
    idle(3);
    @(negedge clk);
    check("t6_stall_hold", {24'd0, qrxd_a}, 32'hC0);
    for (int i = 0; i < 3; i++) begin
      put(0, 1'b1, 8'(8'hD0 + i), 1'b0);
      tick();
    end
    put(0, 1'b1, 8'hD3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_qrxdv", {31'd0, qrxdv_a}, 0);
    check("t6_rst_good",  {16'd0, good_a},  0);
    check("t6_rst_drop",  {16'd0, drop_a},  0);
    for (int i = 4; i < 7; i++) begin
      put(0, 1'b1, 8'(8'hD0 + i), 1'b0);
      tick();
    end
    put(0, 1'b0, 8'h00, 1'b1);
    tick();
    put(0, 1'b0, 8'h00, 1'b0);
    qrxready_a = 1'b1;
    idle(30);
    check("t6_rest_ignored_qrxdv", {31'd0, qrxdv_a}, 0);
    check("t6_rest_ignored_good",  {16'd0, good_a},  0);
    check("t6_rest_ignored_drop",  {16'd0, drop_a},  0);
    expect_pkt(0, 4, 8'hE0);
    send(0, 4, 8'hE0, 3);
    idle(3);
    drain(0, 50);
    check("t6_next_good", {16'd0, good_a}, 1);

    idle(5);
    check("a_queue_left", exp_a.size(), 0);
    check("b_queue_left", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
